muldiv_unit: RTL

Parametrised, iterative RISC-V M-extension execution unit for XLEN-bit cores. Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation over a valid/ready handshake and returns the result with its tag over a second valid/ready handshake. Sits beside the combinational ALU in the execute stage; the ALU keeps the base-integer operations and this unit takes over all M-extension work. Division-by-zero and signed-overflow cases follow the RISC-V spec exactly and complete on a fast path.

---
 rtl/muldiv_pkg.sv | 49 ++++
 rtl/muldiv_core.sv | 83 ++++++++
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative M-extension unit.
//   - funct3 encodings of the eight M-extension operations
//   - FSM state encoding (IDLE, CALC, FIX, DONE)
//   - operand-signedness decode helpers and the legal-XLEN check
package muldiv_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic op_is_div(input logic [2:0] fn);
    return fn[2];
  endfunction

  // REM/REMU return the remainder word instead of the quotient.
  function automatic logic op_is_rem(input logic [2:0] fn);
    return fn[2] & fn[1];
  endfunction

  // rs1 is signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input logic [2:0] fn);
    return (fn == MULDIV_MUL) || (fn == MULDIV_MULH) || (fn == MULDIV_MULHSU) ||
           (fn == MULDIV_DIV) || (fn == MULDIV_REM);
  endfunction

  // rs2 is signed for MUL, MULH, DIV and REM.
  function automatic logic op_signed_b(input logic [2:0] fn);
    return (fn == MULDIV_MUL) || (fn == MULDIV_MULH) ||
           (fn == MULDIV_DIV) || (fn == MULDIV_REM);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: unsigned iterative datapath shared by multiply and divide.
//   clock, reset : clock and synchronous active-high reset
//   load_i       : load magnitudes a_i/b_i and start a fresh operation
//   step_i       : perform one iteration (one product bit or one quotient bit)
//   div_i        : iteration kind, 1 = restoring divide, 0 = shift-add multiply
//   a_i, b_i     : unsigned operand magnitudes (sampled on load_i)
//   acc_o        : 2*XLEN accumulator; after XLEN steps it holds
//                  multiply: the full product
//                  divide  : {remainder, quotient}
import muldiv_pkg::*;

module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;

  // Multiply: the multiplier sits in the low half and is consumed from bit 0;
  // the partial product grows in the high half and everything shifts right.
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] mul_next;

  // Divide: the dividend sits in the low half and is shifted into the partial
  // remainder (high half) one bit at a time; quotient bits enter at bit 0.
  // The shifted remainder is below 2*divisor, so XLEN+1 bits hold it and a
  // trial subtraction in XLEN+2 bits gives a clean borrow bit.
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   diff;
  logic              qbit;
  logic [XLEN-1:0]   new_rem;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
    mul_next = {add_sum, acc_q[XLEN-1:1]};

    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff     = {1'b0, rem_sh} - {2'b00, opb_q};
    qbit     = ~diff[XLEN+1];
    new_rem  = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_next = {new_rem, acc_q[XLEN-2:0], qbit};
  end

  // When qbit=0 the shifted remainder fits XLEN bits; when qbit=1 the
  // difference is below the divisor. Either way the dropped top bit is zero.
  logic unused_core;
  assign unused_core = diff[XLEN];

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, a_i};
      opb_d = b_i;
    end else if (step_i) begin
      acc_d = div_i ? div_next : mul_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) with a tag carried alongside each operation.
//
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   flush             : kills any in-flight or completed-but-untaken result
//   in_valid/in_ready : operation handshake (in_ready high only in IDLE)
//   in_function       : funct3 of the operation
//   in_operand_a/b    : rs1 / rs2 values
//   in_tag            : opaque tag returned with the result
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   out_result, out_tag : result word and its tag, stable while out_valid
//   dbg_state_o       : current FSM state, for observation only
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. in_ready and out_valid are pure functions of
// the state register, never of in_valid/out_ready. flush wins over both
// transfers: an offered operation is not taken and a pending result is dropped.
//
// Latency: the accept edge moves IDLE->CALC, XLEN CALC cycles iterate, one
// FIX cycle applies signs and selects the word, then DONE. Divide-by-zero and
// signed overflow skip straight from IDLE to DONE.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_function,
  input  logic [XLEN-1:0]      in_operand_a,
  input  logic [XLEN-1:0]      in_operand_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output muldiv_state_e        dbg_state_o
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("muldiv_unit: XLEN must be 32 or 64");
  end

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e        state_q, state_d;
  logic [2:0]           func_q, func_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 neg_q, neg_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic [CW-1:0]        counter_q, counter_d;

  // Operand decode, only meaningful while IDLE.
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_by_zero, div_overflow;

  always_comb begin
    sign_a       = op_signed_a(in_function) & in_operand_a[XLEN-1];
    sign_b       = op_signed_b(in_function) & in_operand_b[XLEN-1];
    // Negating the most-negative value yields the same bit pattern, which
    // read as unsigned is exactly its magnitude.
    mag_a        = sign_a ? -in_operand_a : in_operand_a;
    mag_b        = sign_b ? -in_operand_b : in_operand_b;
    div_by_zero  = op_is_div(in_function) && (in_operand_b == '0);
    div_overflow = ((in_function == MULDIV_DIV) || (in_function == MULDIV_REM)) &&
                   (in_operand_a == MOST_NEG) && (in_operand_b == '1);
  end

  // Core control and result fix-up.
  logic              core_load, core_step;
  logic [2*XLEN-1:0] core_acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clock  (clock),
    .reset  (reset),
    .load_i (core_load),
    .step_i (core_step),
    .div_i  (op_is_div(func_q)),
    .a_i    (mag_a),
    .b_i    (mag_b),
    .acc_o  (core_acc)
  );

  always_comb begin
    prod_fix = neg_q ? -core_acc : core_acc;
    quot_fix = neg_q ? -core_acc[XLEN-1:0] : core_acc[XLEN-1:0];
    rem_fix  = neg_q ? -core_acc[2*XLEN-1:XLEN] : core_acc[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    tag_d     = tag_q;
    neg_d     = neg_q;
    result_d  = result_q;
    counter_d = counter_q;
    core_load = 1'b0;
    core_step = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          func_d = in_function;
          tag_d  = in_tag;
          // Remainder follows the dividend; product/quotient follow the XOR.
          neg_d  = op_is_rem(in_function) ? sign_a : (sign_a ^ sign_b);
          if (div_by_zero) begin
            result_d = op_is_rem(in_function) ? in_operand_a : '1;
            state_d  = ST_DONE;
          end else if (div_overflow) begin
            result_d = op_is_rem(in_function) ? '0 : in_operand_a;
            state_d  = ST_DONE;
          end else begin
            core_load = 1'b1;
            counter_d = CNT_INIT;
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        core_step = 1'b1;
        counter_d = counter_q - 1'b1;
        if (counter_q == '0) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (!op_is_div(func_q)) begin
          result_d = (func_q == MULDIV_MUL) ? prod_fix[XLEN-1:0]
                                            : prod_fix[2*XLEN-1:XLEN];
        end else begin
          result_d = op_is_rem(func_q) ? rem_fix : quot_fix;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      func_q    <= '0;
      tag_q     <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      tag_q     <= tag_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
      counter_q <= counter_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign out_result  = result_q;
  assign out_tag     = tag_q;
  assign dbg_state_o = state_q;

endmodule
